wb_stage_skid: RTL

- Parametrised MEM/WB pipeline stage between mem and register.
- Replaces the plain flop stage with a ready/valid handshake and a 2-entry skid buffer, so a stalled register file or write port does not drop a retiring result.
- Adds flush, optional x0 write suppression, and an occupancy count for the stall controller.

---
 rtl/wb_stage_skid_pkg.sv | 15 +
 rtl/wb_payload_reg.sv | 27 ++
 rtl/wb_stage_skid.sv | 118 +++++++++++
 3 files changed

// File: rtl/wb_stage_skid_pkg.sv
// rtl/wb_stage_skid_pkg.sv - shared encodings and constants for the MEM/WB skid stage
package wb_stage_skid_pkg;

    // The state value is also the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    localparam logic ZERO_FILL     = 1'b0;
    localparam logic NO_STALL_FILL = 1'b0;
    localparam logic RESETN_ACTIVE = 1'b0;

endpackage

// File: rtl/wb_payload_reg.sv
// rtl/wb_payload_reg.sv - load-enable payload register with synchronous active-low reset
module wb_payload_reg
    import wb_stage_skid_pkg::*;
#(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_ni == RESETN_ACTIVE) begin
            data_q <= RST_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/wb_stage_skid.sv
// rtl/wb_stage_skid.sv - MEM/WB stage with ready/valid handshake and 2-entry skid buffer
module wb_stage_skid
    import wb_stage_skid_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int STALL_W       = 6,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_rd_data,
    input  logic [ADDR_W-1:0]  in_rd_addr,
    input  logic               in_rd_enable,
    input  logic [STALL_W-1:0] in_stall_flag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  wb_rd_data,
    output logic [ADDR_W-1:0]  wb_rd_addr,
    output logic               wb_rd_enable,
    output logic [STALL_W-1:0] wb_stall_flag,
    output logic [1:0]         occupancy
);

    localparam int PW = DATA_W + ADDR_W + 1 + STALL_W;
    localparam logic [PW-1:0] PAYLOAD_RST = {{STALL_W{NO_STALL_FILL}}, ZERO_FILL,
                                             {ADDR_W{ZERO_FILL}}, {DATA_W{ZERO_FILL}}};

    occ_state_e    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [PW-1:0] h_q, s_q, h_d, in_word;
    logic          h_load, s_load;
    logic          push, pop, in_en_st;

    // x0 writes keep their data/address but are stored with the enable cleared.
    assign in_en_st = in_rd_enable & ~((ZERO_SUPPRESS != 0) && (in_rd_addr == '0));
    assign in_word  = {in_stall_flag, in_en_st, in_rd_addr, in_rd_data};

    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        h_load  = 1'b0;
        s_load  = 1'b0;
        h_d     = in_word;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        h_load  = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        h_load = 1'b1;
                    end else if (push) begin
                        s_load  = 1'b1;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        h_load  = 1'b1;
                        h_d     = s_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Derived from the next state so out_ready never reaches in_ready combinationally.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst == RESETN_ACTIVE) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    wb_payload_reg #(.W(PW), .RST_VAL(PAYLOAD_RST)) u_head (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (h_load),
        .d_i    (h_d),
        .q_o    (h_q)
    );

    wb_payload_reg #(.W(PW), .RST_VAL(PAYLOAD_RST)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (s_load),
        .d_i    (in_word),
        .q_o    (s_q)
    );

    assign in_ready      = in_ready_q;
    assign occupancy     = state_q;
    assign wb_rd_data    = h_q[DATA_W-1:0];
    assign wb_rd_addr    = h_q[DATA_W +: ADDR_W];
    assign wb_rd_enable  = out_valid & h_q[DATA_W+ADDR_W];
    assign wb_stall_flag = h_q[DATA_W+ADDR_W+1 +: STALL_W];

endmodule
